framebuffer_writer: RTL
=======================

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

Interface
REQ-001 SRC_WIDTH, 640, active pixels per incoming camera line.
REQ-002 SRC_HEIGHT, 480, active lines per incoming camera frame.
REQ-003 FB_WIDTH, 320, framebuffer pixels per line (SRC_WIDTH/2).
REQ-004 FB_HEIGHT, 240, framebuffer lines (SRC_HEIGHT/2).
REQ-005 cam_clk_25  in  1  pixel clock; all logic SHALL be on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 capture_en  in  1  level; frames SHALL be accepted only while high at start-of-frame.
REQ-008 pix_valid  in  1  din/sof/eol qualify this cycle; no backpressure exists.
REQ-009 sof  in  1  marks first pixel of a frame; meaningful only with pix_valid.
REQ-010 eol  in  1  marks last pixel of a line; meaningful only with pix_valid.
REQ-011 din  in  8  greyscale pixel.
REQ-012 wr_en  out  1  framebuffer write strobe.
REQ-013 wr_addr  out  17  framebuffer write address.
REQ-014 wr_data  out  2  quantised pixel.
REQ-015 frame_done  out  1  one-cycle pulse after the last write of a frame.
REQ-016 err  out  1  sticky protocol error flag.

Function
REQ-017 States SHALL be IDLE and CAPTURE; reset enters IDLE.
REQ-018 IDLE->CAPTURE on pix_valid&&sof&&capture_en; that pixel is x=0,y=0 and is processed.
REQ-019 IDLE SHALL ignore all pixels without sof, and sof with capture_en low.
REQ-020 In CAPTURE, each pix_valid pixel SHALL increment x (10 bit); eol SHALL clear x and increment y (9 bit).
REQ-021 A pixel SHALL be written iff x[0]==0 and y[0]==0 (2:1 decimation each axis).
REQ-022 Write latency SHALL be exactly one cycle: wr_en/wr_addr/wr_data registered from the accepted pixel.
REQ-023 wr_addr SHALL be 0 for the first write of a frame and increment by 1 per write, ending at FB_WIDTH*FB_HEIGHT-1 (76799); no multiplier.
REQ-024 wr_data SHALL equal din[7:6] (DITHER_EN absent).
REQ-025 eol with y==SRC_HEIGHT-1 SHALL return to IDLE and pulse frame_done in the cycle after that pixel's processing (coincident with wr_en low).
REQ-026 eol with x!=SRC_WIDTH-1 SHALL set err; line still ends, write address SHALL be forced to next line start ((y/2+1)*FB_WIDTH on even y) so later lines stay aligned.
REQ-027 Pixel with x==SRC_WIDTH-1 already reached and no eol SHALL set err; further pixels of that line SHALL be dropped until eol.
REQ-028 sof in CAPTURE SHALL set err and restart the frame at x=0,y=0,addr=0 (if capture_en high, else go IDLE); no frame_done.
REQ-029 err SHALL clear only on reset or on an accepted sof in IDLE.
REQ-030 capture_en dropping mid-frame SHALL NOT abort the frame.

Reset
REQ-031 Reset SHALL force state=IDLE, x=0, y=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, err=0, dither state=0.
REQ-032 Reset asserted mid-frame SHALL discard the frame with no further writes or frame_done.

Configuration
REQ-033 FRAMEBUFFER_WRITER_DITHER_EN defined: wr_data = saturating(din + B)[7:6], B from 2x2 Bayer {0,32;48,16} indexed by {y[1],x[1]}, sum saturating at 255.
REQ-034 Macro undefined: REQ-024 applies; no dither logic synthesised; latency unchanged either way.

Structure
REQ-035 Shared package fb_pkg SHALL hold FB_WIDTH, FB_HEIGHT, FB_ADDR_W (17), FB_PIX_W (2), shared with the VGA read side.
REQ-036 Quantiser (truncate or dither) SHALL be sub-module fb_quantise, purely combinational, one per writer.

Verification
REQ-037 Clean 640x480 frame, din=x[7:0], capture_en=1 -> 76800 writes, addresses 0..76799 contiguous, frame_done once, err=0.
REQ-038 din=8'hC0 at x=2,y=0 -> write addr 1, wr_data 2'b11 one cycle later (no dither).
REQ-039 Line 4 eol at x=500 -> err=1; first write of line 6 at addr 3*320=960.
REQ-040 sof at y=100 mid-frame -> err=1, next write addr 0, exactly one frame_done after subsequent full frame.
REQ-041 capture_en=0 at sof -> zero writes for whole frame, err stays 0.
REQ-042 Reset at y=200 -> wr_en low next cycle, no frame_done; next sof frame starts at addr 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer geometry and types shared by the camera write side and the VGA read side.
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 17;
    localparam int FB_PIX_W  = 2;
    localparam int DATA_W    = 8;
    localparam int SRC_X_W   = 10;
    localparam int SRC_Y_W   = 9;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } fbw_state_e;

    // 2x2 ordered-dither offsets, indexed by {y[1], x[1]}
    function automatic logic [DATA_W-1:0] bayer_offset(input logic y1, input logic x1);
        case ({y1, x1})
            2'b00:   return 8'd0;
            2'b01:   return 8'd32;
            2'b10:   return 8'd48;
            default: return 8'd16;
        endcase
    endfunction

endpackage

// File: rtl/framebuffer_writer_if.sv
// Camera pixel stream in, framebuffer write port out; the writer takes the slave view.
interface framebuffer_writer_if;
    import fb_pkg::*;

    logic                 pix_valid;
    logic                 sof;
    logic                 eol;
    logic [DATA_W-1:0]    din;
    logic                 wr_en;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [FB_PIX_W-1:0]  wr_data;

    modport slave (
        input  pix_valid, sof, eol, din,
        output wr_en, wr_addr, wr_data
    );

    modport master (
        output pix_valid, sof, eol, din,
        input  wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/fb_quantise.sv
// Combinational 8-bit to 2-bit pixel quantiser; ordered dither when
// FRAMEBUFFER_WRITER_DITHER_EN is defined, plain truncation otherwise.
module fb_quantise
    import fb_pkg::*;
(
    input  logic [DATA_W-1:0]   din,
`ifdef FRAMEBUFFER_WRITER_DITHER_EN
    input  logic                x1,
    input  logic                y1,
`endif
    output logic [FB_PIX_W-1:0] q
);

`ifdef FRAMEBUFFER_WRITER_DITHER_EN
    function automatic logic [FB_PIX_W-1:0] sat_quant(input logic [DATA_W:0] s);
        if (s[DATA_W]) return '1;
        return s[DATA_W-1 -: FB_PIX_W];
    endfunction

    logic [DATA_W:0] sum;

    assign sum = {1'b0, din} + {1'b0, bayer_offset(y1, x1)};
    assign q   = sat_quant(sum);
`else
    logic [DATA_W-FB_PIX_W-1:0] unused_lsbs;

    assign unused_lsbs = din[DATA_W-FB_PIX_W-1:0];
    assign q           = din[DATA_W-1 -: FB_PIX_W];
`endif

endmodule

// File: rtl/framebuffer_writer.sv
// Decimates a camera frame 2:1 in each axis into a linear framebuffer.
// Optional ordered dither in the quantiser: FRAMEBUFFER_WRITER_DITHER_EN.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int SRC_WIDTH  = 2 * FB_WIDTH,
    parameter int SRC_HEIGHT = 2 * FB_HEIGHT
) (
    input  logic                 cam_clk_25,
    input  logic                 reset,
    input  logic                 capture_en,
    framebuffer_writer_if.slave  bus,
    output logic                 frame_done,
    output logic                 err
);

    localparam logic [SRC_X_W-1:0]   X_LAST    = SRC_X_W'(SRC_WIDTH - 1);
    localparam logic [SRC_Y_W-1:0]   Y_LAST    = SRC_Y_W'(SRC_HEIGHT - 1);
    localparam logic [FB_ADDR_W-1:0] LINE_STEP = FB_ADDR_W'(SRC_WIDTH / 2);

    fbw_state_e           state_q, state_d;
    logic [SRC_X_W-1:0]   x_q, x_d;
    logic [SRC_Y_W-1:0]   y_q, y_d;
    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [FB_ADDR_W-1:0] base_q, base_d;
    logic                 drop_q, drop_d;
    logic                 err_q, err_d;
    logic                 wr_en_q, wr_en_d;
    logic [FB_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [FB_PIX_W-1:0]  wr_data_q, wr_data_d;
    logic                 frame_done_q, frame_done_d;

    logic                 start_frame;
    logic                 abort_frame;
    logic                 proc;
    logic                 do_wr;
    logic [SRC_X_W-1:0]   cx;
    logic [SRC_Y_W-1:0]   cy;
    logic [FB_ADDR_W-1:0] caddr;
    logic [FB_ADDR_W-1:0] cbase;
    logic                 cdrop;
    logic [FB_PIX_W-1:0]  quant;

    // An accepted sof always processes its pixel as (0,0), both from IDLE and as a restart
    assign start_frame = bus.pix_valid && bus.sof && capture_en;
    assign abort_frame = (state_q == CAPTURE) && bus.pix_valid && bus.sof && !capture_en;
    assign proc        = start_frame || ((state_q == CAPTURE) && bus.pix_valid && !bus.sof);

    assign cx    = start_frame ? '0 : x_q;
    assign cy    = start_frame ? '0 : y_q;
    assign caddr = start_frame ? '0 : addr_q;
    assign cbase = start_frame ? '0 : base_q;
    assign cdrop = start_frame ? 1'b0 : drop_q;
    assign do_wr = proc && !cdrop && !cx[0] && !cy[0];

    fb_quantise u_quant (
        .din (bus.din),
`ifdef FRAMEBUFFER_WRITER_DITHER_EN
        .x1  (cx[1]),
        .y1  (cy[1]),
`endif
        .q   (quant)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        addr_d       = addr_q;
        base_d       = base_q;
        drop_d       = drop_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_frame) begin
                    state_d = CAPTURE;
                    err_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (bus.pix_valid && bus.sof) begin
                    err_d = 1'b1;
                end
                if (abort_frame) begin
                    state_d = IDLE;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    base_d  = '0;
                    drop_d  = 1'b0;
                end
            end
        endcase

        if (proc) begin
            if (do_wr) begin
                wr_en_d   = 1'b1;
                wr_addr_d = caddr;
                wr_data_d = quant;
            end
            x_d    = cx;
            y_d    = cy;
            base_d = cbase;
            drop_d = cdrop;
            addr_d = do_wr ? caddr + 1'b1 : caddr;

            if (bus.eol) begin
                x_d    = '0;
                drop_d = 1'b0;
                if (cx != X_LAST) begin
                    err_d = 1'b1;
                end
                // Re-derive the next line start so a short line cannot skew later lines
                base_d = cy[0] ? cbase : cbase + LINE_STEP;
                addr_d = base_d;
                if (cy == Y_LAST) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    y_d          = '0;
                    addr_d       = '0;
                    base_d       = '0;
                end else begin
                    y_d = cy + 1'b1;
                end
            end else if (!cdrop) begin
                if (cx == X_LAST) begin
                    err_d  = 1'b1;
                    drop_d = 1'b1;
                end else begin
                    x_d = cx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge cam_clk_25) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            base_q       <= '0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            base_q       <= base_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign frame_done  = frame_done_q;
    assign err         = err_q;

endmodule
